// File: rtl/glyph_fetch.sv
// Tile/glyph renderer feeding BitGen: 3-step pixel pipeline from VGA counts to an RGB332 pixel,
// with the counts and bright flag delayed so they stay aligned with pixelData.
module glyph_fetch #(
   parameter int unsigned COLS = 40,
   parameter int unsigned ROWS = 30,
   parameter int unsigned HVID = 640,
   parameter int unsigned VVID = 480,
   parameter int unsigned LAT  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        bright_in,
   output logic [10:0] tile_addr,
   input  logic [7:0]  tile_data,
   output logic [8:0]  glyph_addr,
   input  logic [15:0] glyph_row,
   output logic [7:0]  pixelData,
   output logic [9:0]  hCount_out,
   output logic [9:0]  vCount_out,
   output logic        bright_out
);

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned ADDR_W = 11;

   // The shift-add tile multiply and the stage count are built for this geometry only.
   if (COLS != 40 || ROWS != 30 || LAT != 3) begin : g_param_check
      $error("glyph_fetch supports only COLS=40, ROWS=30, LAT=3");
   end

   logic [CNT_W-1:0]  h_s0, v_s0, h_s1, v_s1;
   logic              bright_s0, bright_s1, vis_s0, vis_s1;
   logic [2:0]        colour_s1;
   logic              vis_c;
   logic [ADDR_W-1:0] tile_addr_c;
   logic              bit_c;
   logic [7:0]        pal_c;
   logic [7:0]        pix_c;

   // Stage 0 address: row*40 + col, with blanking forced to address 0.
   always_comb begin
      vis_c       = (hCount < CNT_W'(HVID)) && (vCount < CNT_W'(VVID));
      tile_addr_c = '0;
      if (vis_c) begin
         tile_addr_c = (ADDR_W'(vCount[9:4]) << 5) + (ADDR_W'(vCount[9:4]) << 3)
                     + ADDR_W'(hCount[9:4]);
      end
   end

   always_comb begin
      pal_c = 8'h00;
      case (colour_s1)
         3'd0: pal_c = 8'h00;
         3'd1: pal_c = 8'h03;
         3'd2: pal_c = 8'h1C;
         3'd3: pal_c = 8'h1F;
         3'd4: pal_c = 8'hE0;
         3'd5: pal_c = 8'hE3;
         3'd6: pal_c = 8'hFC;
         3'd7: pal_c = 8'hFF;
         default: pal_c = 8'h00;
      endcase
   end

   // Bit 15 is the leftmost pixel, so column x selects bit 15-x, i.e. the inverted nibble.
   always_comb begin
      bit_c = glyph_row[~h_s1[3:0]];
      pix_c = (vis_s1 && bright_s1 && bit_c) ? pal_c : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_addr  <= '0;
         h_s0       <= '0;
         v_s0       <= '0;
         bright_s0  <= 1'b0;
         vis_s0     <= 1'b0;
         glyph_addr <= '0;
         colour_s1  <= '0;
         h_s1       <= '0;
         v_s1       <= '0;
         bright_s1  <= 1'b0;
         vis_s1     <= 1'b0;
         pixelData  <= '0;
         hCount_out <= '0;
         vCount_out <= '0;
         bright_out <= 1'b0;
      end else if (pix_en) begin
         tile_addr  <= tile_addr_c;
         h_s0       <= hCount;
         v_s0       <= vCount;
         bright_s0  <= bright_in;
         vis_s0     <= vis_c;

         glyph_addr <= {tile_data[4:0], v_s0[3:0]};
         colour_s1  <= tile_data[7:5];
         h_s1       <= h_s0;
         v_s1       <= v_s0;
         bright_s1  <= bright_s0;
         vis_s1     <= vis_s0;

         pixelData  <= pix_c;
         hCount_out <= h_s1;
         vCount_out <= v_s1;
         bright_out <= bright_s1;
      end
   end

endmodule

// File: tb/tb_glyph_fetch.sv
// Directed-vector bench for glyph_fetch: address map, palette, blanking, reset and stall behaviour.
module tb_glyph_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_en;
   logic [9:0]  hCount, vCount;
   logic        bright_in;
   logic [10:0] tile_addr;
   logic [7:0]  tile_data;
   logic [8:0]  glyph_addr;
   logic [15:0] glyph_row;
   logic [7:0]  pixelData;
   logic [9:0]  hCount_out, vCount_out;
   logic        bright_out;

   int checks = 0;
   int errors = 0;

   glyph_fetch dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .hCount(hCount), .vCount(vCount), .bright_in(bright_in),
      .tile_addr(tile_addr), .tile_data(tile_data),
      .glyph_addr(glyph_addr), .glyph_row(glyph_row),
      .pixelData(pixelData), .hCount_out(hCount_out),
      .vCount_out(vCount_out), .bright_out(bright_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        b;
      logic [7:0]  tile;
      logic [15:0] grow;
      logic [10:0] taddr;
      logic [8:0]  gaddr;
      logic [7:0]  pix;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int h, int v, int b, int tile, int grow,
                               int taddr, int gaddr, int pix);
      vec_t r;
      r.h = 10'(h); r.v = 10'(v); r.b = 1'(b);
      r.tile = 8'(tile); r.grow = 16'(grow);
      r.taddr = 11'(taddr); r.gaddr = 9'(gaddr); r.pix = 8'(pix);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One pixel-enable step: pix_en high across one rising edge, then low for the next.
   task automatic step();
      @(negedge clk) pix_en = 1'b1;
      @(negedge clk) pix_en = 1'b0;
   endtask

   logic [15:0] seq_row = 16'hA5A5;

   function automatic logic [7:0] seq_pix(int h);
      return seq_row[15-h] ? 8'hFF : 8'h00;
   endfunction

   initial begin
      // h, v, bright, tile byte, glyph row, expected tile_addr, glyph_addr, pixel
      vecs.push_back(mk(632, 470, 1, 'h00, 'h0000, 1199, 'h006, 'h00));
      vecs.push_back(mk( 17,  33, 1, 'h21, 'h4000,   81, 'h011, 'h03));
      vecs.push_back(mk(100,  50, 1, 'h85, 'h8000,  126, 'h052, 'h00));
      vecs.push_back(mk( 96,  50, 1, 'h85, 'h8000,  126, 'h052, 'hE0));
      vecs.push_back(mk(700,  50, 1, 'hFF, 'hFFFF,    0, 'h1F2, 'h00));
      vecs.push_back(mk(100, 500, 1, 'hFF, 'hFFFF,    0, 'h1F4, 'h00));
      vecs.push_back(mk(100,  50, 0, 'hFF, 'hFFFF,  126, 'h1F2, 'h00));
      vecs.push_back(mk( 15,   0, 1, 'h3F, 'h0001,    0, 'h1F0, 'h03));
      vecs.push_back(mk( 16,   0, 1, 'h41, 'h8000,    1, 'h010, 'h1C));
      vecs.push_back(mk(639, 479, 1, 'hFF, 'h0001, 1199, 'h1FF, 'hFF));
      vecs.push_back(mk(640,   0, 1, 'hFF, 'hFFFF,    0, 'h1F0, 'h00));
      vecs.push_back(mk(784,   0, 1, 'hFF, 'hFFFF,    0, 'h1F0, 'h00));
      vecs.push_back(mk(  0,   0, 1, 'h00, 'hFFFF,    0, 'h000, 'h00));
      vecs.push_back(mk(  0,   0, 1, 'h20, 'hFFFF,    0, 'h000, 'h03));
      vecs.push_back(mk(  0,   0, 1, 'h40, 'hFFFF,    0, 'h000, 'h1C));
      vecs.push_back(mk(  0,   0, 1, 'h60, 'hFFFF,    0, 'h000, 'h1F));
      vecs.push_back(mk(  0,   0, 1, 'h80, 'hFFFF,    0, 'h000, 'hE0));
      vecs.push_back(mk(  0,   0, 1, 'hA0, 'hFFFF,    0, 'h000, 'hE3));
      vecs.push_back(mk(  0,   0, 1, 'hC0, 'hFFFF,    0, 'h000, 'hFC));
      vecs.push_back(mk(  0,   0, 1, 'hE0, 'hFFFF,    0, 'h000, 'hFF));

      // Reset held with live, non-zero inputs.
      rst_n = 1'b0; pix_en = 1'b0;
      hCount = 10'd100; vCount = 10'd50; bright_in = 1'b1;
      tile_data = 8'hFF; glyph_row = 16'hFFFF;
      #12;
      chk("rst_pix", 32'(pixelData), 32'h0);
      chk("rst_taddr", 32'(tile_addr), 32'h0);
      chk("rst_gaddr", 32'(glyph_addr), 32'h0);
      chk("rst_bright", 32'(bright_out), 32'h0);
      chk("rst_hout", 32'(hCount_out), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // Each vector is held for three steps so the whole pipeline reflects it.
      foreach (vecs[i]) begin
         hCount = vecs[i].h; vCount = vecs[i].v; bright_in = vecs[i].b;
         tile_data = vecs[i].tile; glyph_row = vecs[i].grow;
         repeat (3) step();
         chk($sformatf("v%0d_taddr", i), 32'(tile_addr), 32'(vecs[i].taddr));
         chk($sformatf("v%0d_gaddr", i), 32'(glyph_addr), 32'(vecs[i].gaddr));
         chk($sformatf("v%0d_pix", i), 32'(pixelData), 32'(vecs[i].pix));
         chk($sformatf("v%0d_hout", i), 32'(hCount_out), 32'(vecs[i].h));
         chk($sformatf("v%0d_vout", i), 32'(vCount_out), 32'(vecs[i].v));
         chk($sformatf("v%0d_bright", i), 32'(bright_out), 32'(vecs[i].b));
      end

      // Mid-line reset: outputs clear at once; white pixel returns on the third step.
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_pix", 32'(pixelData), 32'h0);
      chk("mrst_taddr", 32'(tile_addr), 32'h0);
      chk("mrst_bright", 32'(bright_out), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("mrst_s1_pix", 32'(pixelData), 32'h0);
      step();
      chk("mrst_s2_pix", 32'(pixelData), 32'h0);
      chk("mrst_s2_bright", 32'(bright_out), 32'h0);
      step();
      chk("mrst_s3_pix", 32'(pixelData), 32'hFF);
      chk("mrst_s3_bright", 32'(bright_out), 32'h1);

      // Scanning sequence with a 10-clk stall after the fifth step.
      vCount = 10'd16; bright_in = 1'b1; tile_data = 8'hE0; glyph_row = seq_row;
      for (int k = 0; k < 10; k++) begin
         hCount = (k < 8) ? 10'(k) : 10'd7;
         step();
         if (k >= 2) begin
            chk($sformatf("seq%0d_hout", k), 32'(hCount_out), 32'(k - 2));
            chk($sformatf("seq%0d_pix", k), 32'(pixelData), 32'(seq_pix(k - 2)));
         end
         if (k == 4) begin
            hCount = 10'd300;
            for (int s = 0; s < 10; s++) begin
               @(negedge clk);
               chk($sformatf("stall%0d_pix", s), 32'(pixelData), 32'(seq_pix(2)));
               chk($sformatf("stall%0d_hout", s), 32'(hCount_out), 32'd2);
               chk($sformatf("stall%0d_taddr", s), 32'(tile_addr), 32'd40);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/glyph_fetch.md
Name: glyph_fetch

Overview:
- Tile/glyph renderer directly upstream of the VGA BitGen stage.
- Takes the live hCount/vCount/bright from the VGA controller and fetches the tile code for the current 16x16 cell from a 40x30 tile-map RAM.
- Fetches the matching glyph row from a 32-glyph ROM and emits an 8-bit RGB332 pixelData, plus hCount/vCount/bright delayed to stay aligned with it.

Parameters:
- COLS, 40, tiles per row.
- ROWS, 30, tile rows.
- HVID, 640, active pixel width.
- VVID, 480, active pixel height.
- LAT, 3, pipeline depth in pixel-enable steps (fixed; documents latency, not configurable logic).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel-rate enable (1 of every 2 clk); pipeline advances only when high.
- hCount  in  10  current horizontal count from VGA controller.
- vCount  in  10  current vertical count.
- bright_in  in  1  active-video flag from controller.
- tile_addr  out  11  tile-map RAM address, 0..1199.
- tile_data  in  8  tile byte; synchronous RAM, valid one clk after tile_addr changes. Bits [4:0] = glyph index, [7:5] = colour code.
- glyph_addr  out  9  glyph ROM address = {glyph[4:0], row[3:0]}.
- glyph_row  in  16  glyph row; bit 15 = leftmost pixel; synchronous ROM, one clk latency.
- pixelData  out  8  RGB332 pixel for BitGen.
- hCount_out  out  10  hCount delayed LAT pixel steps.
- vCount_out  out  10  vCount delayed LAT pixel steps.
- bright_out  out  1  bright_in delayed LAT pixel steps.

Behaviour:
- Reset (async, rst_n low): tile_addr=0, glyph_addr=0, pixelData=0, hCount_out=0, vCount_out=0, bright_out=0, all pipeline valid/visible flags=0. Release is synchronous to clk; the first pipeline advance is on the first pix_en after release.
- All registers hold when pix_en=0.
- Stage 0 (pix_en edge N):
  - visible0 = (hCount < HVID) && (vCount < VVID).
  - tile_addr <= visible0 ? (vCount[9:4]*COLS + hCount[9:4]) : 0.
  - Capture hCount, vCount, bright_in, visible0.
  - Multiply is by constant 40: implement as (r<<5)+(r<<3), 11-bit result, no overflow for r<=29, c<=39.
- Stage 1 (edge N+1):
  - glyph_addr <= {tile_data[4:0], vCount_s0[3:0]}.
  - colour_s1 <= tile_data[7:5].
  - Forward counts/flags.
- Stage 2 (edge N+2):
  - bit = glyph_row[15 - hCount_s1[3:0]].
  - pixelData <= (visible_s1 && bright_s1 && bit) ? PAL[colour_s1] : 8'h00.
  - hCount_out/vCount_out/bright_out update in the same edge, so outputs describe the same pixel.
- Total latency = 3 pix_en steps: the pixel for input count (h,v) appears with hCount_out=h, vCount_out=v.
- Palette PAL (colour code -> RGB332): 0 black 00, 1 blue 03, 2 green 1C, 3 cyan 1F, 4 red E0, 5 magenta E3, 6 yellow FC, 7 white FF.
- Boundary conditions:
  - hCount>=640 or vCount>=480 (blanking, incl. hCount up to 784): address forced 0, pixel forced 00; no out-of-range RAM access.
  - Tile column wrap: hCount=15 -> 16 moves from tile c to c+1; last active tile col 39 at hCount 624..639.
  - Frame wrap (vCount -> 0) needs no special handling; the pipeline simply flushes through.
  - pix_en held low for many cycles: outputs and addresses frozen, no data lost (memories re-read the same address).
  - rst_n asserted mid-line: all outputs 0 immediately; the first valid pixel returns 3 pix_en steps after resumption.
  - tile_data/glyph_row are sampled only on pix_en edges, so memories need only settle within one clk.

Test Plan:
- Reset: rst_n=0 mid-frame with non-zero inputs -> pixelData=00, tile_addr=0, bright_out=0 asynchronously; hold values until 3rd pix_en after release.
- Address map: hCount=632, vCount=470, visible -> tile_addr=29*40+39=1199; hCount=17, vCount=33 -> tile_addr=2*40+1=81.
- Latency/alignment: drive hCount=100, vCount=50, tile byte 0x85 (red, glyph 5), glyph_row=16'h8000 at row 2 -> after 3 pix_en, hCount_out=100, vCount_out=50, glyph_addr was 9'h052. Pixel hCount%16=4 -> 00; hCount=96 (col 0 of that tile) -> E0.
- Blanking: hCount=700 or vCount=500 with tile RAM returning 0xFF and glyph_row=FFFF -> tile_addr=0, pixelData=00; bright_in=0 inside active area also -> 00.
- Palette sweep: tiles with colour codes 0..7, glyph_row=FFFF -> pixelData sequence 00,03,1C,1F,E0,E3,FC,FF.
- Stall: hold pix_en low 10 clk mid-line -> pixelData, hCount_out, tile_addr unchanged; resuming yields the same pixel sequence as an unstalled reference.
